// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC datapath.
// Runs one control step per clock: a shared fetch (T0..T2), a decode step
// (T3), then a short opcode-specific tail for jal, jr, br, in, out, nop and halt.
// Optional feature: define CU_ILLEGAL_TRAP_EN so that unlisted opcodes trap into
// HALT and raise a sticky 'illegal' flag. Without it they behave as nop and
// 'illegal' is tied low.
module control_unit #(
    parameter int unsigned RA_REG = 15,
    parameter logic [4:0]  ADD_OP = 5'b00011
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR_Data,
    input  logic        CON_out,
    input  logic        go,
    output logic        PC_out,
    output logic        PC_in,
    output logic        IncPC,
    output logic        MAR_in,
    output logic        Z_in,
    output logic        Zlow_out,
    output logic        Y_in,
    output logic        Read,
    output logic        MDR_in,
    output logic        MDR_out,
    output logic        IR_in,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        C_out,
    output logic        CON_in,
    output logic        InPort_out,
    output logic        OutPort_in,
    output logic [15:0] RX_in_man,
    output logic [4:0]  alu_instruction_bits,
    output logic        run,
    output logic        illegal
);

    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3,
        S_J3, S_J4,
        S_R3,
        S_B3, S_B4, S_B5, S_B6,
        S_I3, S_O3,
        S_HALT
    } state_e;

    state_e state_q, state_d;

    logic [4:0] opcode;
    logic       unusedIrBits;

    // Only the opcode field matters here; the remaining IR bits feed the datapath.
    assign opcode       = IR_Data[31:27];
    assign unusedIrBits = ^IR_Data[26:0];

    // State register; reset drops straight back to the first fetch step.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; T3 is the only step that looks at the opcode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_T0: state_d = S_T1;
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                case (opcode)
                    OP_JAL:  state_d = S_J3;
                    OP_JR:   state_d = S_R3;
                    OP_BR:   state_d = S_B3;
                    OP_IN:   state_d = S_I3;
                    OP_OUT:  state_d = S_O3;
                    OP_NOP:  state_d = S_T0;
                    OP_HALT: state_d = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
                    default: state_d = S_HALT;
`else
                    default: state_d = S_T0;
`endif
                endcase
            end
            S_J3:   state_d = S_J4;
            S_J4:   state_d = S_T0;
            S_R3:   state_d = S_T0;
            S_B3:   state_d = S_B4;
            S_B4:   state_d = S_B5;
            S_B5:   state_d = S_B6;
            S_B6:   state_d = S_T0;
            S_I3:   state_d = S_T0;
            S_O3:   state_d = S_T0;
            S_HALT: state_d = go ? S_T0 : S_HALT;
            default: state_d = S_T0;
        endcase
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic legalOp;
    logic illegal_q, illegal_d;

    // Classifies the opcode currently sitting in IR as one this sequencer knows.
    always_comb begin
        legalOp = 1'b0;
        case (opcode)
            OP_BR, OP_JR, OP_JAL, OP_IN, OP_OUT, OP_NOP, OP_HALT: legalOp = 1'b1;
            default: legalOp = 1'b0;
        endcase
    end

    assign illegal_d = illegal_q | ((state_q == S_T3) && !legalOp);

    // Sticky trap flag: set on decoding an unknown opcode, survives go, cleared by reset only.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Moore output decode; strobes are forced low while reset is held, and the
    // branch step is the only place an input (CON_out) reaches an output.
    always_comb begin
        PC_out               = 1'b0;
        PC_in                = 1'b0;
        IncPC                = 1'b0;
        MAR_in               = 1'b0;
        Z_in                 = 1'b0;
        Zlow_out             = 1'b0;
        Y_in                 = 1'b0;
        Read                 = 1'b0;
        MDR_in               = 1'b0;
        MDR_out              = 1'b0;
        IR_in                = 1'b0;
        Gra                  = 1'b0;
        Grb                  = 1'b0;
        Grc                  = 1'b0;
        Rin                  = 1'b0;
        Rout                 = 1'b0;
        BAout                = 1'b0;
        C_out                = 1'b0;
        CON_in               = 1'b0;
        InPort_out           = 1'b0;
        OutPort_in           = 1'b0;
        RX_in_man            = 16'd0;
        alu_instruction_bits = 5'd0;
        run                  = 1'b1;
        if (clr) begin
            case (state_q)
                S_T0: begin
                    PC_out = 1'b1;
                    MAR_in = 1'b1;
                    IncPC  = 1'b1;
                    Z_in   = 1'b1;
                end
                S_T1: begin
                    Zlow_out = 1'b1;
                    PC_in    = 1'b1;
                    Read     = 1'b1;
                    MDR_in   = 1'b1;
                end
                S_T2: begin
                    MDR_out = 1'b1;
                    IR_in   = 1'b1;
                end
                S_J3: begin
                    PC_out    = 1'b1;
                    RX_in_man = 16'd1 << RA_REG;
                end
                S_J4, S_R3: begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    PC_in = 1'b1;
                end
                S_B3: begin
                    Gra    = 1'b1;
                    Rout   = 1'b1;
                    CON_in = 1'b1;
                end
                S_B4: begin
                    PC_out = 1'b1;
                    Y_in   = 1'b1;
                end
                S_B5: begin
                    C_out                = 1'b1;
                    Z_in                 = 1'b1;
                    alu_instruction_bits = ADD_OP;
                end
                S_B6: begin
                    Zlow_out = 1'b1;
                    PC_in    = CON_out;
                end
                S_I3: begin
                    Gra        = 1'b1;
                    Rin        = 1'b1;
                    InPort_out = 1'b1;
                end
                S_O3: begin
                    Gra        = 1'b1;
                    Rout       = 1'b1;
                    OutPort_in = 1'b1;
                end
                S_HALT: begin
                    run = 1'b0;
                end
                default: begin
                    run = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore control sequencer for the Mini SRC datapath; generates, one control step per clock, the strobes that benches currently drive by hand.
- Sits beside the datapath: reads IR_Data and CON_out, drives the datapath's bus in/out, memory, select-encode and ALU-op inputs.
- Scope: fetch plus jal, jr, br*, in, out, nop, halt.

Parameters:
- RA_REG, 15: register index written by jal (return address).
- ADD_OP, 5'b00011: alu_instruction_bits value for the branch-target add.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- IR_Data  in  32  instruction register contents; opcode = IR_Data[31:27].
- CON_out  in  1  branch condition from CON FF logic.
- go  in  1  resume pulse out of HALT.
- PC_out, PC_in, IncPC, MAR_in, Z_in, Zlow_out, Y_in  out  1 each  datapath strobes.
- Read, MDR_in, MDR_out, IR_in  out  1 each  memory/IR strobes.
- Gra, Grb, Grc, Rin, Rout, BAout, C_out, CON_in  out  1 each  select-encode and CON strobes.
- InPort_out, OutPort_in  out  1 each  I/O strobes.
- RX_in_man  out  16  one-hot direct register load; only bit RA_REG is ever set.
- alu_instruction_bits  out  5  ALU op.
- run  out  1  high while sequencing, low in HALT.
- illegal  out  1  sticky illegal-opcode flag (only with macro).

Behaviour:
- Registered state. All outputs are a combinational decode of the state only, with no input-to-output paths except PC_in in BR6.
- clr low, asynchronous: state=T0. All strobes, RX_in_man, alu_instruction_bits and illegal are 0; run=1.
- Fetch:
  - T0: PC_out, MAR_in, IncPC, Z_in.
  - T1: Zlow_out, PC_in, Read, MDR_in.
  - T2: MDR_out, IR_in.
  - T3 decodes the opcode from IR_Data, which is valid from T3 onward.
- jal (10101):
  - J3: PC_out, RX_in_man[RA_REG]=1.
  - J4: Gra, Rout, PC_in. Then T0.
- jr (10100): R3: Gra, Rout, PC_in. Then T0.
- br (10011):
  - B3: Gra, Rout, CON_in.
  - B4: PC_out, Y_in.
  - B5: C_out, Z_in, alu_instruction_bits=ADD_OP.
  - B6: Zlow_out; PC_in = CON_out sampled combinationally in B6. Then T0.
- in (10110): I3: Gra, Rin, InPort_out. Then T0.
- out (10111): O3: Gra, Rout, OutPort_in. Then T0.
- nop (11010): T3 goes straight to T0.
- halt (11011): T3 goes to HALT. HALT: all strobes 0, run=0. Stays until go=1 is sampled, then T0 on the next edge.
- Other opcodes: see Optional Feature.
- Instruction latency in cycles, counting T0 to the next T0: nop 4, jr 5, jal/in/out 5–6 (jal 6, in/out 5), br 8.
- At most one bus driver is asserted in any state. This is a hard invariant and verification asserts it every cycle.
- go outside HALT is ignored. go held high while entering HALT causes exit on the following edge, so HALT lasts one cycle.
- clr mid-instruction aborts immediately to T0. PC and the register file are not touched by the control unit.
- alu_instruction_bits is 0 in every state except B5.

Optional Feature:
- Macro CU_ILLEGAL_TRAP_EN.
- Defined: an opcode not listed above sends T3 to HALT and sets illegal=1. illegal stays set through go and is cleared only by clr.
- Undefined: unlisted opcodes behave as nop and illegal is tied to 0.

Test Plan:
- Reset then fetch: clr low 2 cycles, release, memory[0]=0xD0000000 (nop) -> T0/T1/T2 strobes exact per cycle; PC 0→1; back in T0 after 4 cycles.
- jal: R2=0xF0, memory[0]=0xA9000000 -> R15=1 after J3, PC=0xF0 after J4, fetch restarts at 0xF0.
- jr: R5=0x20, IR=jr R5 -> PC=0x20 after R3; total 5 cycles.
- br taken/not: R3=0 with brzr R3,+4 at PC 0 -> PC=5. Repeat with R3=7 -> PC=1; B6 PC_in mirrors CON_out.
- halt/go: halt at 0 -> run=0, no strobes for 10 cycles; go pulse -> T0 next edge with PC=1.
- Illegal opcode 11111 and mid-instruction reset: with CU_ILLEGAL_TRAP_EN, illegal=1 and run=0; without it, behaves as nop. clr asserted in B4 -> all strobes 0 immediately; T0 after release.
